// File: rtl/cv32e40p_apu_multi_disp.sv
// Generic FIFO: D entries of W bits; rdata_o shows the head while not empty.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: none internally; the caller must not push when full_o is high.
module cv32e40p_apu_multi_disp_fifo #(
   parameter int W = 8,
   parameter int D = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         empty_o,
   output logic         full_o
);
   localparam int PW = $clog2(D);

   logic [W-1:0] mem [D];
   logic [PW-1:0] wp, rp;
   logic [PW:0]   cnt;

   assign rdata_o = mem[rp];
   assign empty_o = (cnt == '0);
   assign full_o  = (cnt == (PW+1)'(D));

   // storage write, no reset needed for the data itself
   always_ff @(posedge clk_i) begin
      if (push_i) mem[wp] <= wdata_i;
   end

   // pointers and occupancy; D is a power of two so pointers wrap naturally
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push_i) wp <= wp + PW'(1);
         if (pop_i)  rp <= rp + PW'(1);
         case ({push_i, pop_i})
            2'b10:   cnt <= cnt + (PW+1)'(1);
            2'b01:   cnt <= cnt - (PW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// Multi-unit APU dispatcher: routes requests to units, returns results in grant order.
// Latency: grant same cycle; result for the head transaction reaches the core 1 cycle after unit rvalid.
// Backpressure: grant withheld when the target unit does not grant or DEPTH transactions are outstanding.
module cv32e40p_apu_multi_disp #(
   parameter int NUM_UNITS = 2,
   parameter int DEPTH     = 4,
   parameter int NARGS     = 3,
   parameter int OP_W      = 6,
   parameter int NDSFLAGS  = 15,
   parameter int NUSFLAGS  = 5,
   parameter int CG_HOLD   = 2,
   parameter int UID_W     = 3
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          core_req_i,
   output logic                          core_gnt_o,
   input  logic [UID_W-1:0]              core_unit_i,
   input  logic [NARGS*32-1:0]           core_operands_i,
   input  logic [OP_W-1:0]               core_op_i,
   input  logic [NDSFLAGS-1:0]           core_flags_i,
   output logic                          core_rvalid_o,
   output logic [31:0]                   core_rdata_o,
   output logic [NUSFLAGS-1:0]           core_rflags_o,
   output logic                          core_err_o,
   output logic                          busy_o,
   output logic [NUM_UNITS-1:0]          unit_req_o,
   input  logic [NUM_UNITS-1:0]          unit_gnt_i,
   output logic [NARGS*32-1:0]           unit_operands_o,
   output logic [OP_W-1:0]               unit_op_o,
   output logic [NDSFLAGS-1:0]           unit_flags_o,
   input  logic [NUM_UNITS-1:0]          unit_rvalid_i,
   input  logic [NUM_UNITS*32-1:0]       unit_rdata_i,
   input  logic [NUM_UNITS*NUSFLAGS-1:0] unit_rflags_i,
   output logic [NUM_UNITS-1:0]          unit_clk_en_o
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int RW = 32 + NUSFLAGS;

   logic             unit_valid, sel_gnt, head_valid, bypass_inv;
   logic             ord_push, ord_pop, ord_empty, ord_full;
   logic [UID_W-1:0] ord_head;
   logic             retire, retire_err;
   logic [RW-1:0]    retire_dat;

   logic [CW-1:0]    outstanding [NUM_UNITS];
   logic [3:0]       hold_cnt    [NUM_UNITS];
   logic [RW-1:0]    res_in      [NUM_UNITS];
   logic [RW-1:0]    res_head    [NUM_UNITS];
   logic [NUM_UNITS-1:0] res_push, res_pop, res_empty, res_full, res_bypass;
   logic [NUM_UNITS-1:0] rpush, unit_inc, unit_dec, unit_act;

   assign unit_operands_o = core_operands_i;
   assign unit_op_o       = core_op_i;
   assign unit_flags_o    = core_flags_i;
   assign busy_o          = ~ord_empty;

   // dispatch: route the request to the selected unit, invalid ids are accepted directly
   always_comb begin
      unit_valid = (32'(core_unit_i) < 32'(NUM_UNITS));
      sel_gnt    = 1'b0;
      unit_req_o = '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
         if (core_unit_i == UID_W'(u)) begin
            sel_gnt       = unit_gnt_i[u];
            unit_req_o[u] = core_req_i & ~ord_full;
         end
      end
      core_gnt_o = core_req_i & ~ord_full & (unit_valid ? sel_gnt : 1'b1);
   end

   // result capture per unit; stray results from idle units are dropped
   always_comb begin
      for (int u = 0; u < NUM_UNITS; u++) begin
         rpush[u]    = unit_rvalid_i[u] & (outstanding[u] != '0) & ~res_full[u];
         res_push[u] = rpush[u] & ~res_bypass[u];
         unit_act[u] = unit_req_o[u] | (outstanding[u] != '0);
         unit_clk_en_o[u] = unit_act[u] | (hold_cnt[u] != 4'd0);
      end
      unit_inc = unit_req_o & {NUM_UNITS{core_gnt_o}};
      unit_dec = res_pop | res_bypass;
   end

   // retire selection: head of the order FIFO, with a same-cycle path for an arriving head result
   // and for an invalid-unit request granted while nothing is outstanding
   always_comb begin
      bypass_inv = core_gnt_o & ~unit_valid & ord_empty;
      head_valid = (32'(ord_head) < 32'(NUM_UNITS));
      retire     = 1'b0;
      retire_err = 1'b0;
      retire_dat = '0;
      res_pop    = '0;
      res_bypass = '0;
      if (bypass_inv) begin
         retire     = 1'b1;
         retire_err = 1'b1;
      end else if (!ord_empty) begin
         if (!head_valid) begin
            retire     = 1'b1;
            retire_err = 1'b1;
         end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
               if (ord_head == UID_W'(u)) begin
                  if (!res_empty[u]) begin
                     retire     = 1'b1;
                     res_pop[u] = 1'b1;
                     retire_dat = res_head[u];
                  end else if (rpush[u]) begin
                     retire        = 1'b1;
                     res_bypass[u] = 1'b1;
                     retire_dat    = res_in[u];
                  end
               end
            end
         end
      end
      ord_push = core_gnt_o & ~bypass_inv;
      ord_pop  = retire & ~bypass_inv;
   end

   cv32e40p_apu_multi_disp_fifo #(.W(UID_W), .D(DEPTH)) i_order_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (ord_push),
      .pop_i   (ord_pop),
      .wdata_i (core_unit_i),
      .rdata_o (ord_head),
      .empty_o (ord_empty),
      .full_o  (ord_full)
   );

   for (genvar g = 0; g < NUM_UNITS; g++) begin : g_res
      assign res_in[g] = {unit_rdata_i[g*32 +: 32], unit_rflags_i[g*NUSFLAGS +: NUSFLAGS]};
      cv32e40p_apu_multi_disp_fifo #(.W(RW), .D(DEPTH)) i_res_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .push_i  (res_push[g]),
         .pop_i   (res_pop[g]),
         .wdata_i (res_in[g]),
         .rdata_o (res_head[g]),
         .empty_o (res_empty[g]),
         .full_o  (res_full[g])
      );
   end

   // per-unit outstanding count and idle hold; hold sits at CG_HOLD while active, then counts down
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int u = 0; u < NUM_UNITS; u++) begin
            outstanding[u] <= '0;
            hold_cnt[u]    <= '0;
         end
      end else begin
         for (int u = 0; u < NUM_UNITS; u++) begin
            if (unit_inc[u] && !unit_dec[u])      outstanding[u] <= outstanding[u] + CW'(1);
            else if (!unit_inc[u] && unit_dec[u]) outstanding[u] <= outstanding[u] - CW'(1);
            if (unit_act[u])              hold_cnt[u] <= 4'(CG_HOLD);
            else if (hold_cnt[u] != 4'd0) hold_cnt[u] <= hold_cnt[u] - 4'd1;
         end
      end
   end

   // registered result port towards the core
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         core_rvalid_o <= 1'b0;
         core_err_o    <= 1'b0;
         core_rdata_o  <= '0;
         core_rflags_o <= '0;
      end else begin
         core_rvalid_o <= retire;
         core_err_o    <= retire_err;
         core_rdata_o  <= retire_dat[RW-1:NUSFLAGS];
         core_rflags_o <= retire_dat[NUSFLAGS-1:0];
      end
   end
endmodule

// File: tb/tb_cv32e40p_apu_multi_disp.sv
// Bench for cv32e40p_apu_multi_disp: directed scenarios then randomized traffic
// against an in-order scoreboard and per-unit result queues.
module tb_cv32e40p_apu_multi_disp;
   localparam int CG_HOLD = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req, core_gnt;
   logic [2:0]  core_unit;
   logic [95:0] core_operands;
   logic [5:0]  core_op;
   logic [14:0] core_flags;
   logic        core_rvalid, core_err, busy;
   logic [31:0] core_rdata;
   logic [4:0]  core_rflags;
   logic [1:0]  unit_req, unit_gnt, unit_rvalid, unit_clk_en;
   logic [95:0] unit_operands;
   logic [5:0]  unit_op;
   logic [14:0] unit_flags;
   logic [63:0] unit_rdata;
   logic [9:0]  unit_rflags;

   always #5 clk = ~clk;

   cv32e40p_apu_multi_disp #(
      .NUM_UNITS(2), .DEPTH(4), .NARGS(3), .OP_W(6), .NDSFLAGS(15),
      .NUSFLAGS(5), .CG_HOLD(CG_HOLD), .UID_W(3)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .core_req_i(core_req), .core_gnt_o(core_gnt), .core_unit_i(core_unit),
      .core_operands_i(core_operands), .core_op_i(core_op), .core_flags_i(core_flags),
      .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata), .core_rflags_o(core_rflags),
      .core_err_o(core_err), .busy_o(busy),
      .unit_req_o(unit_req), .unit_gnt_i(unit_gnt),
      .unit_operands_o(unit_operands), .unit_op_o(unit_op), .unit_flags_o(unit_flags),
      .unit_rvalid_i(unit_rvalid), .unit_rdata_i(unit_rdata), .unit_rflags_i(unit_rflags),
      .unit_clk_en_o(unit_clk_en)
   );

   typedef struct packed {
      logic [2:0]  unit;
      logic [31:0] dat;
      logic [4:0]  flg;
   } txn_t;

   txn_t        sb[$];
   logic [36:0] uq0[$];
   logic [36:0] uq1[$];
   int          last_act [2];
   int          cyc;
   int          vectors;
   int          miscompares;
   int          rv_cnt;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (core_rvalid) rv_cnt++;
   endtask

   // one cycle of random traffic; units behave in-order, results are checked in grant order
   task automatic rand_cycle(input bit allow);
      txn_t        e;
      int          n0, n1;
      bit          v, g, act;
      logic [1:0]  ureq, en;
      logic [36:0] r;
      if (core_rvalid) begin
         if (sb.size() == 0) chk("rnd_unexpected_rvalid", 1, 0);
         else begin
            e = sb.pop_front();
            v = (e.unit < 3'd2);
            chk("rnd_rdata", core_rdata, v ? e.dat : 32'h0);
            chk("rnd_rflags", core_rflags, v ? e.flg : 5'h0);
            chk("rnd_err", core_err, !v);
         end
      end
      n0 = 0;
      n1 = 0;
      foreach (sb[i]) begin
         if (sb[i].unit == 3'd0) n0++;
         if (sb[i].unit == 3'd1) n1++;
      end
      core_req      = allow && ($urandom_range(0, 2) != 0);
      core_unit     = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(2, 7));
      unit_gnt      = 2'($urandom_range(0, 3));
      core_op       = 6'($urandom);
      core_flags    = 15'($urandom);
      core_operands = {$urandom, $urandom, $urandom};
      unit_rvalid   = 2'b00;
      if (uq0.size() > 0 && (!allow || $urandom_range(0, 2) == 0)) begin
         r = uq0.pop_front();
         unit_rvalid[0]    = 1'b1;
         unit_rdata[31:0]  = r[31:0];
         unit_rflags[4:0]  = r[36:32];
      end else if (n0 == 0 && $urandom_range(0, 7) == 0) begin
         unit_rvalid[0]    = 1'b1;
         unit_rdata[31:0]  = $urandom;
      end
      if (uq1.size() > 0 && (!allow || $urandom_range(0, 2) == 0)) begin
         r = uq1.pop_front();
         unit_rvalid[1]    = 1'b1;
         unit_rdata[63:32] = r[31:0];
         unit_rflags[9:5]  = r[36:32];
      end else if (n1 == 0 && $urandom_range(0, 7) == 0) begin
         unit_rvalid[1]    = 1'b1;
         unit_rdata[63:32] = $urandom;
      end
      #1;
      ureq[0] = core_req && (sb.size() < 4) && (core_unit == 3'd0);
      ureq[1] = core_req && (sb.size() < 4) && (core_unit == 3'd1);
      g = core_req && (sb.size() < 4) && ((core_unit < 3'd2) ? unit_gnt[core_unit[0]] : 1'b1);
      chk("rnd_gnt", core_gnt, g);
      chk("rnd_unit_req", unit_req, ureq);
      for (int u = 0; u < 2; u++) begin
         act = ureq[u] || ((u == 0) ? (n0 > 0) : (n1 > 0));
         if (act) last_act[u] = cyc;
         en[u] = act || ((cyc - last_act[u]) <= CG_HOLD);
      end
      chk("rnd_clk_en", unit_clk_en, en);
      if (g) begin
         e.unit = core_unit;
         e.dat  = $urandom;
         e.flg  = 5'($urandom);
         sb.push_back(e);
         if (core_unit == 3'd0) uq0.push_back({e.flg, e.dat});
         else if (core_unit == 3'd1) uq1.push_back({e.flg, e.dat});
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      rv_cnt        = 0;
      cyc           = 0;
      last_act[0]   = -100;
      last_act[1]   = -100;
      rst           = 1'b1;
      core_req      = 1'b0;
      core_unit     = '0;
      core_operands = '0;
      core_op       = '0;
      core_flags    = '0;
      unit_gnt      = '0;
      unit_rvalid   = '0;
      unit_rdata    = '0;
      unit_rflags   = '0;

      // reset state
      @(posedge clk);
      #1;
      chk("rst_rvalid", core_rvalid, 0);
      chk("rst_err", core_err, 0);
      chk("rst_rdata", core_rdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gnt", core_gnt, 0);
      chk("rst_clk_en", unit_clk_en, 0);
      step();
      rst = 1'b0;
      step();

      // single op on unit 0, result three cycles after grant
      core_req = 1'b1; core_unit = 3'd0; unit_gnt = 2'b11;
      core_op = 6'h15; core_flags = 15'h1234; core_operands = {32'h11, 32'h22, 32'h33};
      #1;
      chk("a_gnt", core_gnt, 1);
      chk("a_unit_req", unit_req, 2'b01);
      chk("a_bcast_op", unit_op, 6'h15);
      chk("a_bcast_flags", unit_flags, 15'h1234);
      chk("a_bcast_operands", unit_operands, {32'h11, 32'h22, 32'h33});
      step();
      core_req = 1'b0;
      chk("a_busy", busy, 1);
      chk("a_clk_en_active", unit_clk_en, 2'b01);
      step();
      chk("a_no_rvalid", core_rvalid, 0);
      step();
      unit_rvalid = 2'b01; unit_rdata[31:0] = 32'hCAFE_0001; unit_rflags[4:0] = 5'h0A;
      step();
      unit_rvalid = 2'b00;
      chk("a_rvalid", core_rvalid, 1);
      chk("a_rdata", core_rdata, 32'hCAFE_0001);
      chk("a_rflags", core_rflags, 5'h0A);
      chk("a_err", core_err, 0);
      chk("a_busy_after", busy, 0);
      chk("a_clk_en_hold1", unit_clk_en, 2'b01);
      step();
      chk("a_rvalid_pulse", core_rvalid, 0);
      chk("a_clk_en_hold2", unit_clk_en, 2'b01);
      step();
      chk("a_clk_en_off", unit_clk_en, 2'b00);

      // reorder: unit 1 issued first, unit 0 returns first
      core_req = 1'b1; core_unit = 3'd1;
      #1;
      chk("b_gnt1", core_gnt, 1);
      step();
      core_unit = 3'd0;
      #1;
      chk("b_gnt0", core_gnt, 1);
      step();
      core_req = 1'b0;
      unit_rvalid = 2'b01; unit_rdata[31:0] = 32'h0000_AAAA; unit_rflags[4:0] = 5'h01;
      step();
      chk("b_hold_back", core_rvalid, 0);
      unit_rvalid = 2'b10; unit_rdata[63:32] = 32'h0000_5555; unit_rflags[9:5] = 5'h02;
      step();
      unit_rvalid = 2'b00;
      chk("b_first_rvalid", core_rvalid, 1);
      chk("b_first_rdata", core_rdata, 32'h0000_5555);
      step();
      chk("b_second_rvalid", core_rvalid, 1);
      chk("b_second_rdata", core_rdata, 32'h0000_AAAA);
      chk("b_second_rflags", core_rflags, 5'h01);
      step();
      chk("b_busy", busy, 0);

      // request to a non-existent unit
      core_req = 1'b1; core_unit = 3'd3; unit_gnt = 2'b00;
      #1;
      chk("d_gnt", core_gnt, 1);
      chk("d_unit_req", unit_req, 2'b00);
      step();
      core_req = 1'b0; unit_gnt = 2'b11;
      chk("d_rvalid", core_rvalid, 1);
      chk("d_err", core_err, 1);
      chk("d_rdata", core_rdata, 0);
      chk("d_rflags", core_rflags, 0);
      step();
      chk("d_rvalid_pulse", core_rvalid, 0);
      chk("d_err_clear", core_err, 0);

      // fill all four slots, then a fifth request waits for one retire
      rv_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         core_req = 1'b1; core_unit = 3'd0;
         #1;
         chk("c_fill_gnt", core_gnt, 1);
         step();
      end
      core_unit = 3'd1;
      unit_rvalid = 2'b01; unit_rdata[31:0] = 32'h0000_0C01;
      #1;
      chk("c_full_gnt", core_gnt, 0);
      chk("c_full_unit_req", unit_req, 2'b00);
      step();
      unit_rvalid = 2'b00;
      #1;
      chk("c_freed_gnt", core_gnt, 1);
      chk("c_freed_unit_req", unit_req, 2'b10);
      chk("c_freed_rdata", core_rdata, 32'h0000_0C01);
      step();
      core_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         unit_rvalid = 2'b01; unit_rdata[31:0] = 32'h0000_0C02 + 32'(i);
         step();
      end
      unit_rvalid = 2'b10; unit_rdata[63:32] = 32'h0000_0D01;
      step();
      unit_rvalid = 2'b00;
      chk("c_last_rdata", core_rdata, 32'h0000_0D01);
      step();
      step();
      chk("c_rvalid_count", rv_cnt, 5);
      chk("c_busy", busy, 0);

      // reset with three transactions outstanding, late results must vanish
      for (int i = 0; i < 3; i++) begin
         core_req = 1'b1; core_unit = 3'(i % 2);
         #1;
         chk("e_gnt", core_gnt, 1);
         step();
      end
      core_req = 1'b0;
      rst = 1'b1;
      #1;
      chk("e_rst_busy", busy, 0);
      chk("e_rst_rvalid", core_rvalid, 0);
      chk("e_rst_clk_en", unit_clk_en, 0);
      step();
      rst = 1'b0;
      rv_cnt = 0;
      unit_rvalid = 2'b11;
      step();
      unit_rvalid = 2'b01;
      step();
      unit_rvalid = 2'b00;
      step();
      step();
      chk("e_late_dropped", rv_cnt, 0);
      chk("e_busy", busy, 0);
      chk("e_clk_en", unit_clk_en, 0);
      repeat (4) step();

      // randomized traffic, then drain
      for (int i = 0; i < 1500; i++) rand_cycle(1'b1);
      for (int k = 0; k < 300 && sb.size() > 0; k++) rand_cycle(1'b0);
      chk("drain_outstanding", sb.size(), 0);
      chk("drain_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/cv32e40p_apu_multi_disp.md
# cv32e40p_apu_multi_disp

Multi-unit APU dispatcher placed between the core APU port and NUM_UNITS independent accelerator units (FPU lanes, custom units). It routes each granted request to the unit chosen by the core. It reorders unit results so they return to the core in issue order, and it generates a per-unit clock enable with a programmable idle hold. It generalises the single-FPU hookup with its `apu_req | apu_busy` clock gate into N channels with outstanding-transaction tracking.

## Interface
Parameters:
- NUM_UNITS, default 2: number of attached units (1..8).
- DEPTH, default 4: maximum outstanding transactions in total (power of 2, ≥2).
- NARGS, default 3: operands per request.
- OP_W, default 6: opcode width.
- NDSFLAGS, default 15: downstream flag width.
- NUSFLAGS, default 5: upstream flag width.
- CG_HOLD, default 2: cycles the unit clock enable stays high after the unit goes idle (0..15).
- UID_W, default 3: width of the unit-select field; must satisfy 2^UID_W ≥ NUM_UNITS.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset. One clock; reset is asynchronous and active-high.
- core_req_i, in, 1: core request.
- core_gnt_o, out, 1: request accepted this cycle.
- core_unit_i, in, UID_W: target unit index.
- core_operands_i, in, NARGS×32: operands.
- core_op_i, in, OP_W: opcode.
- core_flags_i, in, NDSFLAGS: downstream flags.
- core_rvalid_o, out, 1: one-cycle result pulse.
- core_rdata_o, out, 32: result data.
- core_rflags_o, out, NUSFLAGS: result flags.
- core_err_o, out, 1: qualifies core_rvalid_o; set for a request to a non-existent unit.
- busy_o, out, 1: at least one transaction outstanding or buffered.
- unit_req_o, out, NUM_UNITS: per-unit request.
- unit_gnt_i, in, NUM_UNITS: per-unit grant.
- unit_operands_o, unit_op_o, unit_flags_o, out: broadcast copies of the core fields.
- unit_rvalid_i, in, NUM_UNITS: per-unit result valid.
- unit_rdata_i, in, NUM_UNITS×32: per-unit result data.
- unit_rflags_i, in, NUM_UNITS×NUSFLAGS: per-unit result flags.
- unit_clk_en_o, out, NUM_UNITS: per-unit clock enable, fed to the existing clock-gate cell.

## Operation
- Order FIFO: DEPTH entries of UID_W bits. It records the unit id of every granted request. It is full when DEPTH transactions are outstanding, counted from grant until the result is delivered to the core.
- Dispatch (combinational):
  - valid = core_unit_i < NUM_UNITS.
  - unit_req_o[u] = core_req_i & ~full & valid & (core_unit_i == u).
  - core_gnt_o = core_req_i & ~full & (valid ? unit_gnt_i[core_unit_i] : 1).
  - The broadcast fields are copied unconditionally.
- On core_gnt_o: push core_unit_i into the order FIFO and increment outstanding[core_unit_i] (3-bit+ counter sized for DEPTH).
- Result buffers:
  - Each unit has a FIFO of DEPTH entries × (32+NUSFLAGS). It cannot overflow, because total outstanding ≤ DEPTH.
  - On unit_rvalid_i[u] with outstanding[u] > 0: push the result. A unit rvalid with outstanding[u] == 0 is dropped.
- Retire: at most one transaction per cycle.
  - Head id h valid and result FIFO h non-empty: pop both, register the data into core_rdata_o/core_rflags_o, and pulse core_rvalid_o the next cycle.
  - Head id invalid: pop, output rdata 0, rflags 0, core_rvalid_o=1 and core_err_o=1.
  - Decrement outstanding[h] on retire.
- Units are assumed in-order internally. Cross-unit completion order is arbitrary, and the core always sees results in grant order.
- Clock enable: unit_clk_en_o[u] = unit_req_o[u] | (outstanding[u] > 0) | (hold_cnt[u] != 0).
  - hold_cnt[u] is loaded with CG_HOLD on the cycle the unit's activity term falls from 1 to 0.
  - It then decrements to 0 and reloads if activity resumes.
- busy_o = order FIFO non-empty.
- Reset clears all FIFOs, counters and hold counters. Every output then follows its combinational definition; all registered outputs (core_rvalid_o, core_rdata_o, core_rflags_o, core_err_o) are 0.

## Timing
- Grant: same cycle as request when the target unit grants and the order FIFO is not full.
- Result latency: a unit rvalid at cycle t for the head transaction produces core_rvalid_o at t+1. If it is not the head, the result waits in its buffer and retires one cycle after each earlier transaction retires.
- Invalid-unit request granted at t: core_rvalid_o/core_err_o at t+1 if it is at the head.
- Full: core_gnt_o=0 and all unit_req_o=0. A same-cycle retire does not free a slot until the next cycle.
- Simultaneous grant and retire on the same unit: the counter is unchanged.
- Simultaneous push and pop on the same result FIFO: both happen.
- Reset asserted mid-transaction: in-flight results are lost and no core_rvalid_o is produced for them. Units share rst_i.

## Test plan
- Single unit, op to unit 0, unit returns at t+3 → core_gnt_o at t, core_rvalid_o at t+4 with matching data, busy_o low after retire.
- Unit 1 issued then unit 0; unit 0 returns first (0xAAAA) then unit 1 (0x5555) → core receives 0x5555 then 0xAAAA, in consecutive cycles.
- Issue DEPTH=4 requests with no results → 5th request sees core_gnt_o=0 and unit_req_o=0; after one retire it is granted the next cycle.
- core_unit_i=3 with NUM_UNITS=2 → granted immediately, core_rvalid_o=1, core_err_o=1, rdata 0.
- CG_HOLD=2, single op retires at cycle t → unit_clk_en_o[u] stays high through t+2 and is low at t+3; other units' enables remain 0 throughout.
- rst_i asserted with 3 outstanding → all outputs are at reset values immediately; subsequent late unit rvalids are dropped and produce no core_rvalid_o.
